pll_reconfig_seq: RTL
=====================

# pll_reconfig_seq

Sequencer that drives the Altera PLL reconfiguration management port (mgmt_* of pll_cfg) to switch the video/system PLL between native and 60 Hz-underclocked fractional settings. It sits between the core's option/ROM-header flags (underclock option bit, bootleg PCB flag) and pll_cfg, in the CLK_50M management domain. It synchronizes and filters the request flags, coalesces changes, performs the mode/K-counter/start write sequence with waitrequest handshaking, then supervises PLL relock.

## Interface
Parameters:
- K_SEL0, 3639383488, fractional K value for sel=00 (native, original PCB)
- K_SEL1, 2971430088, K for sel=01 (underclock, original PCB)
- K_SEL2, 3639383488, K for sel=10 (native, bootleg PCB)
- K_SEL3, 2971430088, K for sel=11 (underclock, bootleg PCB)
- STABLE_CYCLES, 4, cycles a synchronized sel value must hold before it is acted on (1..255)
- LOCK_DROP, 16, cycles after start write during which locked is ignored
- LOCK_TIMEOUT, 65535, max cycles to wait for relock after LOCK_DROP

Ports:
- clk  in  1  management clock (CLK_50M)
- reset  in  1  synchronous, active-high
- underclock  in  1  async; sel[0]
- bootleg  in  1  async; sel[1]
- pll_locked  in  1  async PLL lock
- mgmt_waitrequest  in  1  from pll_cfg
- mgmt_write  out  1  write strobe
- mgmt_address  out  6  register address
- mgmt_writedata  out  32  register data
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- lock_err  out  1  last sequence timed out waiting for lock (sticky)
- cur_sel  out  2  sel value last programmed

## Operation
- underclock, bootleg, pll_locked each pass a 2-flop synchronizer; sel = {bootleg_s, underclock_s}.
- Stability filter: 8-bit counter reloads to 0 whenever sel differs from previous cycle's sel; sel is "stable" when counter reaches STABLE_CYCLES (saturates).
- Request when stable sel != cur_sel, or force flag set. force is set by reset, cleared when a sequence starts (PLL state unknown after reset).
- Changes arriving while busy are not lost: on return to IDLE the stable sel is re-compared; multiple changes during one sequence coalesce into at most one follow-up sequence using the latest stable value.
- States: IDLE → MODE_WR (addr 0, data 0) → K_WR (addr 7, data K_SELn of latched sel) → START_WR (addr 2, data 0) → LOCK_DROP (count LOCK_DROP) → LOCK_WAIT → IDLE.
- Sel is latched into target on leaving IDLE; cur_sel <= target when START_WR is accepted.
- Write handshake: mgmt_write high with address/data held constant until a cycle where mgmt_waitrequest=0 (accept); mgmt_write low the next cycle; exactly one idle cycle (write low) before the next write.
- LOCK_WAIT: locked_s=1 → done pulse, lock_err <= 0, IDLE. Counter reaching LOCK_TIMEOUT → done pulse, lock_err <= 1, IDLE.
- busy = (state != IDLE).

## Timing
- Reset values: mgmt_write 0, mgmt_address 0, mgmt_writedata 0, busy 0, done 0, lock_err 0, cur_sel 00, state IDLE, force 1, filter counter 0.
- Reset asserted mid-sequence: all outputs at reset values on the following edge; mgmt_write drops immediately, no further writes until reset release.
- Input-to-write latency: mgmt_write rises exactly STABLE_CYCLES+3 edges after the first edge at which a new level is present and held.
- With waitrequest held low: writes high at cycles W, W+2, W+4; LOCK_DROP begins W+5; earliest done at W+5+LOCK_DROP+1 (locked_s already 1).
- waitrequest high stretches the current write only; no timeout on waitrequest.
- Sel pulse shorter than STABLE_CYCLES (synchronized) is ignored.
- done and busy=0 occur on the same edge; a pending request raises busy one cycle later at earliest.

## Test plan
- Reset release, sel=00, waitrequest=0, locked=1: writes (0,0),(7,3639383488),(2,0) at W,W+2,W+4; done pulse at W+22; cur_sel=00, lock_err=0.
- After idle, underclock 0→1 held: write data 2971430088 on addr 7; cur_sel=01; exactly one sequence.
- waitrequest high 10 cycles during K_WR: mgmt_write/addr/data stable 11 cycles, single acceptance, next write 2 cycles after acceptance.
- underclock pulse of STABLE_CYCLES-1 synchronized cycles: no mgmt_write, busy stays 0.
- bootleg 0→1 then 1→0 then 0→1 during a running sequence: that sequence completes, exactly one follow-up with K_SEL3 (sel=11), then IDLE.
- locked forced 0: done pulse after LOCK_DROP+LOCK_TIMEOUT, lock_err=1; reset asserted during K_WR wait: mgmt_write 0 next edge, full sequence reruns after release.

Source files
------------

// File: rtl/pll_reconfig_seq.sv
// Sequences the PLL reconfig management port between native and underclocked K values.
// Write goes out STABLE_CYCLES+3 edges after a held input change; waitrequest stretches the current write only.
module pll_reconfig_seq #(
  parameter logic [31:0] K_SEL0        = 32'd3639383488,
  parameter logic [31:0] K_SEL1        = 32'd2971430088,
  parameter logic [31:0] K_SEL2        = 32'd3639383488,
  parameter logic [31:0] K_SEL3        = 32'd2971430088,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned LOCK_DROP     = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        underclock,
  input  logic        bootleg,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        busy,
  output logic        done,
  output logic        lock_err,
  output logic [1:0]  cur_sel
);

  localparam int unsigned TMAX = (LOCK_DROP > LOCK_TIMEOUT) ? LOCK_DROP : LOCK_TIMEOUT;
  localparam int          TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DROP_LAST    = TW'(LOCK_DROP - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [7:0]    STABLE_CNT   = 8'(STABLE_CYCLES);

  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_K     = 6'd7;
  localparam logic [5:0] ADDR_START = 6'd2;

  typedef enum logic [2:0] {
    IDLE,
    MODE_WR,
    MODE_GAP,
    K_WR,
    K_GAP,
    START_WR,
    LOCK_DROP_ST,
    LOCK_WAIT
  } state_t;

  state_t state, state_nxt;

  // Bit order: {pll_locked, bootleg, underclock}
  logic [2:0] sync1, sync2;
  logic [1:0] sel;
  logic       locked_s;

  logic [1:0] prev_sel;
  logic [7:0] stab_cnt;
  logic       stable;

  logic          force_pend;
  logic          req;
  logic [1:0]    target;
  logic [TW-1:0] timer;
  logic          seq_end;
  logic          accept;
  logic [31:0]   k_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {pll_locked, bootleg, underclock};
      sync2 <= sync1;
    end
  end

  assign sel      = sync2[1:0];
  assign locked_s = sync2[2];

  // prev_sel doubles as the filtered value: it only counts as stable once the
  // counter has seen it unchanged for STABLE_CYCLES comparisons.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sel <= 2'b00;
      stab_cnt <= 8'd0;
    end else begin
      prev_sel <= sel;
      if (sel != prev_sel)
        stab_cnt <= 8'd0;
      else if (stab_cnt != STABLE_CNT)
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  assign stable = (stab_cnt == STABLE_CNT);
  assign req    = stable && (force_pend || (prev_sel != cur_sel));
  assign accept = mgmt_write && !mgmt_waitrequest;

  always_comb begin
    k_val = K_SEL0;
    case (target)
      2'b00:   k_val = K_SEL0;
      2'b01:   k_val = K_SEL1;
      2'b10:   k_val = K_SEL2;
      default: k_val = K_SEL3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    mgmt_write     = 1'b0;
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    seq_end        = 1'b0;
    case (state)
      IDLE: begin
        if (req)
          state_nxt = MODE_WR;
      end
      MODE_WR: begin
        mgmt_write   = 1'b1;
        mgmt_address = ADDR_MODE;
        if (!mgmt_waitrequest)
          state_nxt = MODE_GAP;
      end
      MODE_GAP: begin
        state_nxt = K_WR;
      end
      K_WR: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_K;
        mgmt_writedata = k_val;
        if (!mgmt_waitrequest)
          state_nxt = K_GAP;
      end
      K_GAP: begin
        state_nxt = START_WR;
      end
      START_WR: begin
        mgmt_write   = 1'b1;
        mgmt_address = ADDR_START;
        if (!mgmt_waitrequest)
          state_nxt = LOCK_DROP_ST;
      end
      LOCK_DROP_ST: begin
        if (timer == DROP_LAST)
          state_nxt = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        if (locked_s || (timer == TIMEOUT_LAST)) begin
          seq_end   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // One timer serves both the lock-drop blanking window and the relock timeout.
  always_ff @(posedge clk) begin
    if (reset)
      timer <= '0;
    else if (state_nxt != state)
      timer <= '0;
    else if ((state == LOCK_DROP_ST) || (state == LOCK_WAIT))
      timer <= timer + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      force_pend <= 1'b1;
      target     <= 2'b00;
      cur_sel    <= 2'b00;
      done       <= 1'b0;
      lock_err   <= 1'b0;
    end else begin
      done <= seq_end;
      if ((state == IDLE) && req) begin
        target     <= prev_sel;
        force_pend <= 1'b0;
      end
      if ((state == START_WR) && accept)
        cur_sel <= target;
      if (seq_end)
        lock_err <= !locked_s;
    end
  end

endmodule
